pipe_ctrl: RTL and testbench

Pipeline stall/flush controller for the five-stage MIPS core. It merges stall requests from fetch, decode, execute and memory into the 6-bit `stall` vector consumed by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb). It accepts exceptions and `eret` from the memory stage, issuing a one-cycle `flush` and the redirect PC. A small FSM discards an instruction fetch that is still outstanding when the flush happens, and a watchdog flags stalls that never clear.

---
 rtl/pipe_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//
// Stall/flush controller for the five-stage MIPS pipeline. It merges the stall
// requests from fetch, decode, execute and memory into one stall vector. It
// accepts exceptions and eret from the MEM stage, raising a one-cycle flush
// together with the redirect PC. A two-state FSM (RUN/DRAIN) throws away an
// instruction fetch that is still in flight when a flush happens. A watchdog
// raises a sticky flag when a stall never clears.
//
// Ports
//   clk            in   1   system clock
//   rst            in   1   synchronous reset, active low
//   stallreq_if    in   1   instruction SRAM not ready
//   stallreq_id    in   1   load-use hazard
//   stallreq_ex    in   1   multi-cycle EX operation busy
//   stallreq_mem   in   1   data SRAM not ready
//   excepttype_i   in  32   MEM-stage exception code (0 none, 32'hE eret)
//   cp0_epc_i      in  32   current EPC, target of eret
//   stall          out  6   [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb
//   flush          out  1   clear all pipeline registers
//   new_pc         out 32   redirect target, valid while flush=1
//   if_discard     out  1   drop the fetch that returns this cycle
//   stall_timeout  out  1   sticky watchdog flag
//   perf_stall_cnt out 32   number of cycles with stall[0]=1 (wraps)
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
    parameter logic [15:0] STALL_LIMIT = 16'd1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        if_discard,
    output logic        stall_timeout,
    output logic [31:0] perf_stall_cnt
);

    localparam logic [31:0] ERET_CODE = 32'h0000_000E;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_run_len;
    logic        r_timeout;
    logic [31:0] r_perf_cnt;

    logic        w_exc_accept;

    // Combinational control. These outputs act in the same cycle, so they
    // depend only on the inputs and the state register.
    always_comb begin
        stall        = 6'b000000;
        flush        = 1'b0;
        new_pc       = 32'h0;
        if_discard   = 1'b0;
        w_exc_accept = 1'b0;
        if (rst) begin
            if (r_state == ST_DRAIN) begin
                // The pipeline is already empty. Hold PC/IF until the stale
                // fetch has come back, and ignore every other request.
                stall      = 6'b000011;
                if_discard = 1'b1;
            end else if ((excepttype_i != 32'h0) && !stallreq_mem) begin
                // A stalled MEM stage keeps the exception pending. When it
                // is accepted, the flush overrides every stall request.
                w_exc_accept = 1'b1;
                flush        = 1'b1;
                new_pc       = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
            end else if (stallreq_mem) begin
                stall = 6'b011111;
            end else if (stallreq_ex) begin
                stall = 6'b001111;
            end else if (stallreq_id) begin
                stall = 6'b000111;
            end else if (stallreq_if) begin
                stall = 6'b000011;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_run_len  <= 16'h0;
            r_timeout  <= 1'b0;
            r_perf_cnt <= 32'h0;
        end else begin
            // DRAIN lasts through the first cycle that sees stallreq_if=0,
            // because the fetch completes in that cycle and must still be
            // discarded.
            if (r_state == ST_RUN) begin
                if (w_exc_accept && stallreq_if) begin
                    r_state <= ST_DRAIN;
                end
            end else begin
                if (!stallreq_if) begin
                    r_state <= ST_RUN;
                end
            end

            if (r_run_len == STALL_LIMIT) begin
                r_timeout <= 1'b1;
            end

            if (stall[0]) begin
                if (r_run_len != 16'hFFFF) begin
                    r_run_len <= r_run_len + 16'd1;
                end
                r_perf_cnt <= r_perf_cnt + 32'd1;
            end else begin
                r_run_len <= 16'h0;
            end
        end
    end

    assign stall_timeout  = r_timeout;
    assign perf_stall_cnt = r_perf_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//
// Self-checking bench for pipe_ctrl. It runs a directed vector table, a few
// hand-written multi-cycle sequences, and a randomized phase checked against a
// behavioural model.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;
    localparam int          LIMIT   = 8;

    logic        clk;
    logic        rst;
    logic        sif, sid, sex, smem;
    logic [31:0] exc, epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        if_discard;
    logic        stall_timeout;
    logic [31:0] perf_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl #(
        .EXC_VECTOR (EXC_VEC),
        .STALL_LIMIT(16'(LIMIT))
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (sif),
        .stallreq_id   (sid),
        .stallreq_ex   (sex),
        .stallreq_mem  (smem),
        .excepttype_i  (exc),
        .cp0_epc_i     (epc),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .if_discard    (if_discard),
        .stall_timeout (stall_timeout),
        .perf_stall_cnt(perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        disc;
    } outs_t;

    bit          m_drain = 1'b0;
    int          m_run   = 0;
    bit          m_to    = 1'b0;
    logic [31:0] m_perf  = 32'h0;

    // The stall vector freezes the first n stages, counted from the PC.
    function automatic outs_t model_out(bit drain);
        outs_t o;
        int    n;
        o = '0;
        n = 0;
        if (rst !== 1'b1) begin
            return o;
        end
        if (drain) begin
            n      = 2;
            o.disc = 1'b1;
        end else if (exc != 0 && !smem) begin
            o.flush  = 1'b1;
            o.new_pc = (exc == 32'hE) ? epc : EXC_VEC;
        end else begin
            if (smem)     n = 5;
            else if (sex) n = 4;
            else if (sid) n = 3;
            else if (sif) n = 2;
        end
        o.stall = 6'((1 << n) - 1);
        return o;
    endfunction

    always @(posedge clk) begin
        outs_t e;
        e = model_out(m_drain);
        if (rst !== 1'b1) begin
            m_drain <= 1'b0;
            m_run   <= 0;
            m_to    <= 1'b0;
            m_perf  <= 32'h0;
        end else begin
            if (m_run == LIMIT) m_to <= 1'b1;
            if (e.stall[0]) begin
                m_run  <= (m_run < 65535) ? m_run + 1 : 65535;
                m_perf <= m_perf + 32'd1;
            end else begin
                m_run <= 0;
            end
            if (m_drain)      m_drain <= sif;
            else if (e.flush) m_drain <= sif;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input logic r, input logic i_f, input logic i_d, input logic i_e,
                         input logic i_m, input logic [31:0] x, input logic [31:0] p);
        rst = r; sif = i_f; sid = i_d; sex = i_e; smem = i_m; exc = x; epc = p;
    endtask

    // Called at the negedge: compares every DUT output with the model.
    task automatic check_model(input string tag);
        outs_t e;
        e = model_out(m_drain);
        chk({tag, ".stall"},   {26'h0, stall},     {26'h0, e.stall});
        chk({tag, ".flush"},   {31'h0, flush},     {31'h0, e.flush});
        chk({tag, ".new_pc"},  new_pc,             e.new_pc);
        chk({tag, ".discard"}, {31'h0, if_discard}, {31'h0, e.disc});
        chk({tag, ".timeout"}, {31'h0, stall_timeout}, {31'h0, m_to});
        chk({tag, ".perf"},    perf_stall_cnt,     m_perf);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r, f, d, e, m;
        logic [31:0] x, p;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] np;
        logic        ds;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic f, input logic d, input logic e, input logic m,
                       input logic [31:0] x, input logic [31:0] p,
                       input logic [5:0] st, input logic fl, input logic [31:0] np, input logic ds);
        vec_t v;
        v.r = r; v.f = f; v.d = d; v.e = e; v.m = m; v.x = x; v.p = p;
        v.st = st; v.fl = fl; v.np = np; v.ds = ds;
        vecs.push_back(v);
    endtask

    initial begin
        drive(0, 1, 1, 1, 1, 32'h1, 32'h0);
        // reset: outputs forced low whatever the inputs are
        add(0, 1, 1, 1, 1, 32'h1,  32'h0,         6'b000000, 0, 32'h0, 0);
        add(0, 1, 0, 0, 0, 32'hE,  32'h1111_2222, 6'b000000, 0, 32'h0, 0);
        // stall priority
        add(1, 0, 1, 1, 0, 32'h0,  32'h0,         6'b001111, 0, 32'h0, 0);
        add(1, 0, 1, 1, 1, 32'h0,  32'h0,         6'b011111, 0, 32'h0, 0);
        add(1, 0, 0, 0, 0, 32'h0,  32'h0,         6'b000000, 0, 32'h0, 0);
        add(1, 0, 1, 0, 0, 32'h0,  32'h0,         6'b000111, 0, 32'h0, 0);
        add(1, 1, 0, 0, 0, 32'h0,  32'h0,         6'b000011, 0, 32'h0, 0);
        add(1, 1, 1, 0, 0, 32'h0,  32'h0,         6'b000111, 0, 32'h0, 0);
        // exception redirect and eret
        add(1, 0, 0, 0, 0, 32'h1,  32'h0,         6'b000000, 1, EXC_VEC, 0);
        add(1, 0, 0, 0, 0, 32'h0,  32'h0,         6'b000000, 0, 32'h0, 0);
        add(1, 0, 0, 0, 0, 32'hE,  32'h8000_1234, 6'b000000, 1, 32'h8000_1234, 0);
        add(1, 0, 0, 0, 0, 32'h0,  32'h8000_1234, 6'b000000, 0, 32'h0, 0);
        // exception blocked by the MEM stall for 3 cycles
        add(1, 0, 0, 0, 1, 32'h4,  32'h0,         6'b011111, 0, 32'h0, 0);
        add(1, 0, 0, 0, 1, 32'h4,  32'h0,         6'b011111, 0, 32'h0, 0);
        add(1, 0, 0, 0, 1, 32'h4,  32'h0,         6'b011111, 0, 32'h0, 0);
        add(1, 0, 0, 0, 0, 32'h4,  32'h0,         6'b000000, 1, EXC_VEC, 0);
        add(1, 0, 0, 0, 0, 32'h0,  32'h0,         6'b000000, 0, 32'h0, 0);
        // flush wins over ex/id stalls, with no drain
        add(1, 0, 1, 1, 0, 32'h8,  32'h0,         6'b000000, 1, EXC_VEC, 0);
        add(1, 0, 0, 0, 0, 32'h0,  32'h0,         6'b000000, 0, 32'h0, 0);
        // drain: flush, three discard cycles (exceptions ignored), then RUN
        add(1, 1, 0, 0, 0, 32'h1,  32'h0,         6'b000000, 1, EXC_VEC, 0);
        add(1, 1, 0, 0, 0, 32'h1,  32'h0,         6'b000011, 0, 32'h0, 1);
        add(1, 1, 1, 0, 1, 32'hE,  32'h5555_0000, 6'b000011, 0, 32'h0, 1);
        add(1, 0, 0, 1, 0, 32'h1,  32'h0,         6'b000011, 0, 32'h0, 1);
        add(1, 0, 0, 0, 0, 32'h0,  32'h0,         6'b000000, 0, 32'h0, 0);

        next_cycle();
        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].f, vecs[i].d, vecs[i].e, vecs[i].m, vecs[i].x, vecs[i].p);
            @(negedge clk);
            chk($sformatf("vec%0d.stall", i),   {26'h0, stall},      {26'h0, vecs[i].st});
            chk($sformatf("vec%0d.flush", i),   {31'h0, flush},      {31'h0, vecs[i].fl});
            chk($sformatf("vec%0d.new_pc", i),  new_pc,              vecs[i].np);
            chk($sformatf("vec%0d.discard", i), {31'h0, if_discard}, {31'h0, vecs[i].ds});
            check_model($sformatf("vec%0d.model", i));
            next_cycle();
        end

        // ---------------- watchdog, LIMIT=8, EX stall for 10 cycles ----------------
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        next_cycle();
        for (int c = 1; c <= 10; c++) begin
            drive(1, 0, 0, 1, 0, 32'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("wd.c%0d.stall", c), {26'h0, stall}, 32'h0000_000F);
            chk($sformatf("wd.c%0d.timeout", c), {31'h0, stall_timeout}, (c >= 10) ? 32'h1 : 32'h0);
            chk($sformatf("wd.c%0d.perf", c), perf_stall_cnt, 32'(c - 1));
            next_cycle();
        end
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("wd.release.timeout", {31'h0, stall_timeout}, 32'h1);
        chk("wd.release.perf", perf_stall_cnt, 32'd10);
        next_cycle();
        @(negedge clk);
        chk("wd.sticky.timeout", {31'h0, stall_timeout}, 32'h1);
        next_cycle();

        // ---------------- reset in the middle of DRAIN ----------------
        drive(1, 1, 0, 0, 0, 32'h2, 32'h0);
        @(negedge clk);
        chk("rstdrain.flush", {31'h0, flush}, 32'h1);
        next_cycle();
        drive(1, 1, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rstdrain.in_drain", {31'h0, if_discard}, 32'h1);
        next_cycle();
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rstdrain.rst.stall", {26'h0, stall}, 32'h0);
        chk("rstdrain.rst.discard", {31'h0, if_discard}, 32'h0);
        next_cycle();
        drive(1, 1, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rstdrain.after.discard", {31'h0, if_discard}, 32'h0);
        chk("rstdrain.after.stall", {26'h0, stall}, 32'h0000_0003);
        chk("rstdrain.after.perf", perf_stall_cnt, 32'h0);
        chk("rstdrain.after.timeout", {31'h0, stall_timeout}, 32'h0);
        next_cycle();

        // ---------------- randomized phase against the model ----------------
        for (int c = 0; c < 400; c++) begin
            logic [31:0] x;
            x = 32'h0;
            if ($urandom_range(3) == 0) begin
                x = ($urandom_range(1) == 0) ? 32'hE : ($urandom | 32'h1);
            end
            drive(($urandom_range(39) != 0),
                  ($urandom_range(2) == 0), ($urandom_range(3) == 0),
                  ($urandom_range(4) == 0), ($urandom_range(5) == 0),
                  x, $urandom);
            @(negedge clk);
            check_model($sformatf("rnd%0d", c));
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
